clk_div_ctrl: RTL

//  Run-time controller for the system clock divider. Accepts new half-period

---
 rtl/clk_ctrl_pkg.sv | 12 +
 rtl/clk_div_core.sv | 47 ++++
 rtl/clk_div_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the run-time clock divider controller.
package clk_ctrl_pkg;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned DEFAULT_HALF = 250;
  localparam int unsigned CYC_W        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and output toggle; rise/fall strobes flag the edge
// that will occur on the next clock.
module clk_div_core
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = clk_ctrl_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             clk_out_o,
  output logic             rise_o,
  output logic             fall_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             term;

  always_comb begin
    term   = (cnt_q == half_i);
    rise_o = run_i & term & ~clk_q;
    fall_o = run_i & term & clk_q;
    cnt_d  = cnt_q + CNT_W'(1);
    clk_d  = clk_q;
    // Dropping run parks the divider low with a cleared count.
    if (!run_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (term) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_out_o = clk_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: start/stop sequencing, glitch-free ratio updates at
// full-period boundaries, and a count of output periods.
module clk_div_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = clk_ctrl_pkg::CNT_W,
  parameter int unsigned DEFAULT_HALF = clk_ctrl_pkg::DEFAULT_HALF,
  parameter int unsigned CYC_W        = clk_ctrl_pkg::CYC_W
) (
  input  logic             clk_in_50M,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CYC_W-1:0] period_cnt
);
  ctrl_state_t      state_q;
  logic [CNT_W-1:0] active_half_q, pend_half_q;
  logic             pend_vld_q, tick_q, cfg_err_q;
  logic [CYC_W-1:0] period_q;
  logic             xfer, good, trunc, run, rise, fall, to_idle;

  always_comb begin
    cfg_ready = (state_q == IDLE) | ~pend_vld_q;
    xfer      = cfg_valid & cfg_ready;
    good      = xfer & (cfg_half != '0);
    trunc     = (state_q == RUN) & stop & ~clk_out;
    run       = (state_q != IDLE) & ~trunc;
  end

  // A stop seen while high finishes the period; if that is the falling edge itself, go straight home.
  assign to_idle = trunc | (fall & ((state_q == DRAIN) | ((state_q == RUN) & stop)));

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk_i     (clk_in_50M),
    .rst_i     (reset),
    .run_i     (run),
    .half_i    (active_half_q),
    .clk_out_o (clk_out),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  always_ff @(posedge clk_in_50M or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      active_half_q <= CNT_W'(DEFAULT_HALF);
      pend_half_q   <= '0;
      pend_vld_q    <= 1'b0;
      tick_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      period_q      <= '0;
    end else begin
      tick_q    <= rise;
      cfg_err_q <= xfer & (cfg_half == '0);
      if (rise) period_q <= period_q + CYC_W'(1);
      case (state_q)
        IDLE: begin
          if (good) active_half_q <= cfg_half;
          if (start && !stop) begin
            state_q  <= RUN;
            period_q <= '0;
          end
        end
        default: begin
          if (to_idle) begin
            // Whatever ratio is waiting becomes active as soon as we are idle.
            state_q    <= IDLE;
            pend_vld_q <= 1'b0;
            if (good) active_half_q <= cfg_half;
            else if (pend_vld_q) active_half_q <= pend_half_q;
          end else begin
            if (fall && pend_vld_q) begin
              active_half_q <= pend_half_q;
              pend_vld_q    <= 1'b0;
            end
            if (good) begin
              pend_half_q <= cfg_half;
              pend_vld_q  <= 1'b1;
            end
            if (state_q == RUN && stop) state_q <= DRAIN;
          end
        end
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign tick       = tick_q;
  assign cfg_err    = cfg_err_q;
  assign period_cnt = period_q;
endmodule
